// File: rtl/rom_download_ctrl_if.sv
// Host download bus (ioctl_*) plus the ROM write bus (dn_*) it is converted into.
interface rom_download_ctrl_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  ioctl_wait, dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output ioctl_wait, dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/rom_download_ctrl.sv
// ROM download controller: forwards index-0 host bytes to the core ROM, latches index-1 config,
// holds the core in reset until the image is complete. Write pacing enabled by ROM_DOWNLOAD_CTRL_PACING_EN.
module rom_download_ctrl #(
    parameter int ROM_SIZE    = 16384,
    parameter int HOLD_CYCLES = 16,
    parameter int WR_GAP      = 2
) (
    input  logic               clk_sys,
    input  logic               reset,
    rom_download_ctrl_if.slave bus,
    output logic               core_reset,
    output logic [1:0]         game_mode,
    output logic [1:0]         overlay_type,
    output logic               rom_ok,
    output logic               err
);
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_LOAD = 2'd1;
    localparam logic [1:0]  ST_GAP  = 2'd2;
    localparam logic [1:0]  ST_HOLD = 2'd3;

    localparam logic [14:0] ROM_SIZE_W = 15'(ROM_SIZE);
    localparam logic [24:0] ROM_LIMIT  = 25'(ROM_SIZE);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0]  GAP_LAST   = 4'(WR_GAP - 1);

    logic [1:0]  state_reg, state_next;
    logic [14:0] cnt_reg, cnt_next;
    logic [7:0]  hold_cnt_reg, hold_cnt_next;
    logic [3:0]  gap_cnt_reg, gap_cnt_next;
    logic [7:0]  index_reg, index_next;
    logic        wait_reg, wait_next;
    logic        dn_wr_reg, dn_wr_next;
    logic [13:0] dn_addr_reg, dn_addr_next;
    logic [7:0]  dn_data_reg, dn_data_next;
    logic        core_reset_reg, core_reset_next;
    logic [1:0]  game_mode_reg, game_mode_next;
    logic [1:0]  overlay_reg, overlay_next;
    logic        rom_ok_reg, rom_ok_next;
    logic        err_reg, err_next;

    logic        start_load;
    logic        enter_hold;
    logic        is_rom_wr;
    logic        addr_in_rom;
    logic        is_cfg_wr;

    assign is_rom_wr   = (bus.ioctl_index == 8'd0);
    assign addr_in_rom = (bus.ioctl_addr < ROM_LIMIT);
    assign is_cfg_wr   = (bus.ioctl_index == 8'd1) && (bus.ioctl_addr == 25'd0);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        index_next     = index_reg;
        dn_wr_next     = 1'b0;
        dn_addr_next   = dn_addr_reg;
        dn_data_next   = dn_data_reg;
        game_mode_next = game_mode_reg;
        overlay_next   = overlay_reg;
        rom_ok_next    = rom_ok_reg;
        err_next       = err_reg;
        start_load     = 1'b0;
        enter_hold     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                start_load = bus.ioctl_download;
            end
            ST_LOAD: begin
                // A dropping download wins over a write presented in the same cycle.
                if (!bus.ioctl_download) begin
                    enter_hold = 1'b1;
                end else if (bus.ioctl_wr) begin
                    if (is_rom_wr) begin
                        if (addr_in_rom) begin
                            dn_wr_next   = 1'b1;
                            dn_addr_next = bus.ioctl_addr[13:0];
                            dn_data_next = bus.ioctl_dout;
                            if (cnt_reg != ROM_SIZE_W) begin
                                cnt_next = cnt_reg + 15'd1;
                            end
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (is_cfg_wr) begin
                        game_mode_next = bus.ioctl_dout[1:0];
                        overlay_next   = bus.ioctl_dout[3:2];
                    end
`ifdef ROM_DOWNLOAD_CTRL_PACING_EN
                    state_next   = ST_GAP;
                    gap_cnt_next = 4'd0;
`endif
                end
            end
            ST_GAP: begin
                if (!bus.ioctl_download) begin
                    enter_hold = 1'b1;
                end else begin
                    if (bus.ioctl_wr) begin
                        err_next = 1'b1;
                    end
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_next = ST_LOAD;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 4'd1;
                    end
                end
            end
            default: begin
                if (bus.ioctl_download) begin
                    start_load = 1'b1;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next    = ST_IDLE;
                    hold_cnt_next = 8'd0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
        endcase

        if (start_load) begin
            state_next    = ST_LOAD;
            cnt_next      = 15'd0;
            hold_cnt_next = 8'd0;
            rom_ok_next   = 1'b0;
            err_next      = 1'b0;
            index_next    = bus.ioctl_index;
        end

        // The image is good only if an index-0 download delivered every byte.
        if (enter_hold) begin
            state_next    = ST_HOLD;
            hold_cnt_next = 8'd0;
            if ((cnt_reg == ROM_SIZE_W) && (index_reg == 8'd0)) begin
                rom_ok_next = 1'b1;
            end
        end
    end

`ifdef ROM_DOWNLOAD_CTRL_PACING_EN
    assign wait_next = (state_next == ST_GAP);
`else
    assign wait_next = 1'b0;
`endif

    assign core_reset_next = (state_next != ST_IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 15'd0;
            hold_cnt_reg   <= 8'd0;
            gap_cnt_reg    <= 4'd0;
            index_reg      <= 8'd0;
            wait_reg       <= 1'b0;
            dn_wr_reg      <= 1'b0;
            dn_addr_reg    <= 14'd0;
            dn_data_reg    <= 8'd0;
            core_reset_reg <= 1'b1;
            game_mode_reg  <= 2'd0;
            overlay_reg    <= 2'd0;
            rom_ok_reg     <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            index_reg      <= index_next;
            wait_reg       <= wait_next;
            dn_wr_reg      <= dn_wr_next;
            dn_addr_reg    <= dn_addr_next;
            dn_data_reg    <= dn_data_next;
            core_reset_reg <= core_reset_next;
            game_mode_reg  <= game_mode_next;
            overlay_reg    <= overlay_next;
            rom_ok_reg     <= rom_ok_next;
            err_reg        <= err_next;
        end
    end

    assign bus.ioctl_wait = wait_reg;
    assign bus.dn_wr      = dn_wr_reg;
    assign bus.dn_addr    = dn_addr_reg;
    assign bus.dn_data    = dn_data_reg;
    assign core_reset     = core_reset_reg;
    assign game_mode      = game_mode_reg;
    assign overlay_type   = overlay_reg;
    assign rom_ok         = rom_ok_reg;
    assign err            = err_reg;
endmodule

// File: tb/tb_rom_download_ctrl.sv
// Bench for rom_download_ctrl: directed download scenarios plus random traffic,
// every cycle compared against a time-stamp based reference model.
module tb_rom_download_ctrl;
    localparam int ROM_SIZE    = 4096;
    localparam int HOLD_CYCLES = 16;
    localparam int WR_GAP      = 2;
`ifdef ROM_DOWNLOAD_CTRL_PACING_EN
    localparam bit PACING = 1'b1;
`else
    localparam bit PACING = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       core_reset;
    logic [1:0] game_mode;
    logic [1:0] overlay_type;
    logic       rom_ok;
    logic       err;

    rom_download_ctrl_if bus ();

    rom_download_ctrl #(
        .ROM_SIZE    (ROM_SIZE),
        .HOLD_CYCLES (HOLD_CYCLES),
        .WR_GAP      (WR_GAP)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .bus          (bus),
        .core_reset   (core_reset),
        .game_mode    (game_mode),
        .overlay_type (overlay_type),
        .rom_ok       (rom_ok),
        .err          (err)
    );

    always #5 clk_sys = ~clk_sys;

    int total_checks = 0;
    int bad_checks   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a download session is open or closed; pacing and hold are time windows.
    bit          m_in_dl     = 1'b0;
    bit          m_in_hold   = 1'b0;
    int          m_hold_since = 0;
    int          m_gap_until = -1000;
    int          m_cnt       = 0;
    int          m_idx       = 0;
    logic        m_rom_ok    = 1'b0;
    logic        m_err       = 1'b0;
    logic [1:0]  m_gm        = 2'd0;
    logic [1:0]  m_ov        = 2'd0;
    logic        m_dn_wr     = 1'b0;
    logic [13:0] m_dn_addr   = 14'd0;
    logic [7:0]  m_dn_data   = 8'd0;
    logic        m_core_rst  = 1'b1;
    logic        m_wait      = 1'b0;

    task automatic model_open();
        m_in_dl     = 1'b1;
        m_in_hold   = 1'b0;
        m_cnt       = 0;
        m_rom_ok    = 1'b0;
        m_err       = 1'b0;
        m_idx       = int'(bus.ioctl_index);
        m_gap_until = -1000;
    endtask

    task automatic model_edge(input int t);
        int a;
        a = int'(bus.ioctl_addr);
        m_dn_wr = 1'b0;
        if (reset) begin
            m_in_dl = 1'b0; m_in_hold = 1'b0; m_cnt = 0; m_rom_ok = 1'b0; m_err = 1'b0;
            m_gm = 2'd0; m_ov = 2'd0; m_dn_addr = 14'd0; m_dn_data = 8'd0; m_gap_until = -1000;
        end else if (m_in_dl) begin
            if (!bus.ioctl_download) begin
                m_in_dl = 1'b0; m_in_hold = 1'b1; m_hold_since = t;
                if (m_cnt == ROM_SIZE && m_idx == 0) m_rom_ok = 1'b1;
            end else if (bus.ioctl_wr) begin
                if (PACING && t <= m_gap_until) begin
                    m_err = 1'b1;
                end else begin
                    if (bus.ioctl_index == 8'd0) begin
                        if (a < ROM_SIZE) begin
                            m_dn_wr = 1'b1; m_dn_addr = 14'(a % 16384); m_dn_data = bus.ioctl_dout;
                            if (m_cnt < ROM_SIZE) m_cnt++;
                        end else begin
                            m_err = 1'b1;
                        end
                    end else if (bus.ioctl_index == 8'd1 && a == 0) begin
                        m_gm = bus.ioctl_dout[1:0];
                        m_ov = bus.ioctl_dout[3:2];
                    end
                    if (PACING) m_gap_until = t + WR_GAP;
                end
            end
        end else if (m_in_hold) begin
            if (bus.ioctl_download) model_open();
            else if (t == m_hold_since + HOLD_CYCLES) m_in_hold = 1'b0;
        end else if (bus.ioctl_download) begin
            model_open();
        end
        m_core_rst = reset ? 1'b1 : (m_in_dl || m_in_hold);
        m_wait     = (!reset) && PACING && m_in_dl && (t + 1 <= m_gap_until);
    endtask

    int cyc       = 0;
    int dn_seen   = 0;
    int wait_seen = 0;

    always @(posedge clk_sys) begin
        model_edge(cyc);
        cyc++;
        #1;
        check_val($sformatf("outputs c%0d", cyc),
                  {1'b0, bus.ioctl_wait, bus.dn_wr, bus.dn_addr, bus.dn_data, core_reset, game_mode, overlay_type, rom_ok, err},
                  {1'b0, m_wait, m_dn_wr, m_dn_addr, m_dn_data, m_core_rst, m_gm, m_ov, m_rom_ok, m_err});
        if (bus.dn_wr) dn_seen++;
        if (bus.ioctl_wait) wait_seen++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic host_write(input logic [7:0] idx, input int addr, input logic [7:0] data, input int gap);
        bus.ioctl_index = idx;
        bus.ioctl_addr  = 25'(addr);
        bus.ioctl_dout  = data;
        bus.ioctl_wr    = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_wr    = 1'b0;
        repeat (gap) @(negedge clk_sys);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] idx;
        int         n_ops;
        int         addr;

        reset = 1'b1;
        bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0;
        bus.ioctl_dout = '0; bus.ioctl_index = '0;
        idle(3);
        check_val("reset core_reset", core_reset, 1);
        check_val("reset dn_wr", bus.dn_wr, 0);
        check_val("reset wait", bus.ioctl_wait, 0);
        reset = 1'b0;
        idle(1);
        check_val("idle core_reset", core_reset, 0);

        // Full paced index-0 download
        dn_seen = 0; wait_seen = 0;
        bus.ioctl_index = 8'd0; bus.ioctl_download = 1'b1;
        idle(1);
        for (int a = 0; a < ROM_SIZE; a++) host_write(8'd0, a, a[7:0], WR_GAP);
        bus.ioctl_download = 1'b0;
        idle(1);
        check_val("full dn count", dn_seen, ROM_SIZE);
        check_val("full wait cycles", wait_seen, PACING ? ROM_SIZE * WR_GAP : 0);
        check_val("full rom_ok", rom_ok, 1);
        check_val("full err", err, 0);
        check_val("full wait low in hold", bus.ioctl_wait, 0);
        idle(HOLD_CYCLES - 1);
        check_val("hold core_reset", core_reset, 1);
        idle(1);
        check_val("hold end core_reset", core_reset, 0);

        // Index-1 config write
        bus.ioctl_index = 8'd1; bus.ioctl_download = 1'b1;
        idle(1);
        host_write(8'd1, 0, 8'h0E, 0);
        check_val("cfg game_mode", game_mode, 2);
        check_val("cfg overlay", overlay_type, 3);
        check_val("cfg no dn_wr", bus.dn_wr, 0);
        idle(WR_GAP);
        host_write(8'd1, 5, 8'hFF, WR_GAP);
        host_write(8'd2, 0, 8'hFF, WR_GAP);
        check_val("cfg other addr", game_mode, 2);
        check_val("cfg other err", err, 0);
        bus.ioctl_download = 1'b0;
        idle(HOLD_CYCLES + 2);

        // Out-of-range write, then a complete image with duplicates past ROM_SIZE
        bus.ioctl_index = 8'd0; bus.ioctl_download = 1'b1;
        idle(1);
        host_write(8'd0, ROM_SIZE, 8'h55, 0);
        check_val("oor no dn_wr", bus.dn_wr, 0);
        check_val("oor err", err, 1);
        idle(WR_GAP);
        for (int a = 0; a < ROM_SIZE; a++) host_write(8'd0, a, 8'($urandom), WR_GAP);
        for (int k = 0; k < 3; k++) host_write(8'd0, 7, 8'h77, WR_GAP);
        bus.ioctl_download = 1'b0;
        idle(1);
        check_val("sat rom_ok", rom_ok, 1);
        check_val("sat err sticky", err, 1);

        // Download re-asserted 5 cycles into hold
        idle(4);
        bus.ioctl_download = 1'b1;
        idle(1);
        check_val("rearm core_reset", core_reset, 1);
        check_val("rearm rom_ok", rom_ok, 0);
        check_val("rearm err", err, 0);

        // Back-to-back writes: second one lands inside the gap
        dn_seen = 0;
        bus.ioctl_index = 8'd0; bus.ioctl_addr = 25'd10; bus.ioctl_dout = 8'hA1; bus.ioctl_wr = 1'b1;
        idle(1);
        bus.ioctl_addr = 25'd11; bus.ioctl_dout = 8'hB2;
        idle(1);
        bus.ioctl_wr = 1'b0;
        idle(WR_GAP);
        check_val("b2b dn count", dn_seen, PACING ? 1 : 2);
        check_val("b2b err", err, PACING ? 1 : 0);
        bus.ioctl_download = 1'b0;
        idle(HOLD_CYCLES + 2);

        // Reset in the middle of a download
        bus.ioctl_index = 8'd0; bus.ioctl_download = 1'b1;
        idle(1);
        for (int a = 0; a < 100; a++) host_write(8'd0, a, 8'(a + 3), WR_GAP);
        reset = 1'b1;
        idle(2);
        check_val("mid reset core_reset", core_reset, 1);
        check_val("mid reset dn_addr", bus.dn_addr, 0);
        check_val("mid reset dn_data", bus.dn_data, 0);
        check_val("mid reset game_mode", game_mode, 0);
        check_val("mid reset overlay", overlay_type, 0);
        check_val("mid reset wait", bus.ioctl_wait, 0);
        reset = 1'b0;
        idle(1);
        check_val("post reset load", core_reset, 1);
        for (int a = 0; a < ROM_SIZE - 1; a++) host_write(8'd0, a, a[7:0], WR_GAP);
        bus.ioctl_download = 1'b0;
        idle(1);
        check_val("restart count short", rom_ok, 0);
        idle(HOLD_CYCLES + 2);

        // Random traffic
        for (int d = 0; d < 40; d++) begin
            idx = 8'($urandom_range(0, 2));
            bus.ioctl_index = idx;
            bus.ioctl_download = 1'b1;
            idle($urandom_range(0, 1));
            n_ops = $urandom_range(1, 25);
            for (int k = 0; k < n_ops; k++) begin
                if (idx == 8'd1) addr = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40);
                else if ($urandom_range(0, 4) == 0) addr = ROM_SIZE + $urandom_range(0, 1000);
                else addr = $urandom_range(0, ROM_SIZE - 1);
                host_write(idx, addr, 8'($urandom), $urandom_range(0, WR_GAP + 1));
            end
            bus.ioctl_download = 1'b0;
            idle($urandom_range(1, HOLD_CYCLES + 4));
        end
        idle(HOLD_CYCLES + 2);
        check_val("final core_reset", core_reset, 0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
